// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: lane steering, load extraction,
// ack handshake with stall generation, LL/SC link and alignment checks.
module data_mem_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWord,
    input  logic        MemHalf,
    input  logic        MemSignExtend,
    input  logic        LLSC,
    input  logic        Eret,
    input  logic        IF_Stall,
    output logic [31:0] ReadData,
    output logic        M_Stall,
    output logic        EXC_AdEL,
    output logic        EXC_AdES,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ack,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        link_v_q, link_v_d;
    logic [29:0] link_a_q, link_a_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_st, is_ld, is_sc, is_ll;
    logic        misal, link_hit, sc_fail;
    logic        req, issue, done_now;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_val, result;
    logic [3:0]  lanes;
    logic [31:0] wdata;

    // MemWrite takes priority when both strobes are (illegally) set
    assign is_st    = MemWrite;
    assign is_ld    = MemRead & ~MemWrite;
    assign is_sc    = is_st & LLSC;
    assign is_ll    = is_ld & LLSC;
    assign misal    = MemWord ? (Address[1:0] != 2'b00)
                              : (MemHalf & Address[0]);
    assign link_hit = link_v_q & (link_a_q == Address[31:2]);
    assign sc_fail  = is_sc & ~link_hit;
    assign req      = (MemRead | MemWrite) & ~misal & ~sc_fail;
    assign issue    = req & (state_q != DONE) & ~reset;
    assign done_now = issue & DataMem_Ack;

    always_comb begin
        byte_v = DataMem_In[31:24];
        unique case (Address[1:0])
            2'd0: byte_v = DataMem_In[31:24];
            2'd1: byte_v = DataMem_In[23:16];
            2'd2: byte_v = DataMem_In[15:8];
            2'd3: byte_v = DataMem_In[7:0];
        endcase
        half_v = Address[1] ? DataMem_In[15:0] : DataMem_In[31:16];
        if (MemWord)
            ld_val = DataMem_In;
        else if (MemHalf)
            ld_val = {{16{MemSignExtend & half_v[15]}}, half_v};
        else
            ld_val = {{24{MemSignExtend & byte_v[7]}}, byte_v};
        if (is_sc)
            result = 32'd1;
        else if (is_ld)
            result = ld_val;
        else
            result = 32'd0;
    end

    always_comb begin
        if (MemWord) begin
            lanes = 4'b1111;
            wdata = DataIn;
        end else if (MemHalf) begin
            lanes = Address[1] ? 4'b0011 : 4'b1100;
            wdata = {2{DataIn[15:0]}};
        end else begin
            lanes = 4'b1000 >> Address[1:0];
            wdata = {4{DataIn[7:0]}};
        end
    end

    assign DataMem_Address = reset ? 30'd0 : Address[31:2];
    assign DataMem_Out     = reset ? 32'd0 : wdata;
    assign DataMem_Read    = issue & is_ld;
    assign DataMem_Write   = (issue & is_st) ? lanes : 4'b0000;
    assign M_Stall         = issue & ~DataMem_Ack;
    assign EXC_AdEL        = ~reset & is_ld & misal;
    assign EXC_AdES        = ~reset & is_st & misal;

    always_comb begin
        if (reset)
            ReadData = 32'd0;
        else if (state_q == DONE)
            ReadData = rdata_q;
        else if (done_now)
            ReadData = result;
        else
            ReadData = 32'd0;
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        link_v_d = link_v_q;
        link_a_d = link_a_q;
        unique case (state_q)
            IDLE, WAIT: begin
                if (done_now) begin
                    rdata_d = result;
                    state_d = IF_Stall ? DONE : IDLE;
                end else if (req) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: if (!IF_Stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a successful SC is itself a store to the link word
        if (done_now && is_ll) begin
            link_v_d = 1'b1;
            link_a_d = Address[31:2];
        end
        if (done_now && is_st && link_hit)
            link_v_d = 1'b0;
        if (Eret)
            link_v_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rdata_q  <= 32'd0;
            link_v_q <= 1'b0;
            link_a_q <= 30'd0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            link_v_q <= link_v_d;
            link_a_q <= link_a_d;
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: expected load/SC results are queued
// when a request is driven and popped on the acknowledging cycle.
module tb_data_mem_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, DataIn;
    logic        MemRead, MemWrite, MemWord, MemHalf, MemSignExtend;
    logic        LLSC, Eret, IF_Stall;
    logic [31:0] ReadData;
    logic        M_Stall, EXC_AdEL, EXC_AdES;
    logic [31:0] DataMem_In;
    logic        DataMem_Ack;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    data_mem_controller dut (
        .clock(clk), .reset(reset), .Address(Address), .DataIn(DataIn),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemWord(MemWord),
        .MemHalf(MemHalf), .MemSignExtend(MemSignExtend), .LLSC(LLSC),
        .Eret(Eret), .IF_Stall(IF_Stall), .ReadData(ReadData),
        .M_Stall(M_Stall), .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES),
        .DataMem_In(DataMem_In), .DataMem_Ack(DataMem_Ack),
        .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
        .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Address = 0; DataIn = 0; MemRead = 0; MemWrite = 0;
        MemWord = 0; MemHalf = 0; MemSignExtend = 0; LLSC = 0;
        Eret = 0; IF_Stall = 0; DataMem_In = 0; DataMem_Ack = 0;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            e = 32'hxxxxxxxx;
            n_err++;
            $display("FAIL scoreboard_empty");
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        MemRead = 1; MemWord = 1; Address = 32'h100;
        tick(); tick();
        n_cmp++;
        if (DataMem_Read !== 1'b0) begin
            n_err++; $display("FAIL rst_read got=%0b exp=0", DataMem_Read);
        end
        idle();
        #1;
        n_cmp++;
        if (ReadData !== 32'd0) begin
            n_err++; $display("FAIL rst_rdata got=%h exp=0", ReadData);
        end
        n_cmp++;
        if (M_Stall !== 1'b0 || DataMem_Write !== 4'b0) begin
            n_err++;
            $display("FAIL rst_stall_we got=%0b/%b exp=0/0000", M_Stall, DataMem_Write);
        end
        tick();
        reset = 0;
    endtask

    task automatic test_lw_zero_wait();
        tick();
        Address = 32'h100; MemRead = 1; MemWord = 1;
        DataMem_In = 32'h11223344; DataMem_Ack = 1;
        exp_q.push_back(32'h11223344);
        #1;
        n_cmp++;
        if (DataMem_Read !== 1'b1 || M_Stall !== 1'b0) begin
            n_err++;
            $display("FAIL lw_strobe got=%0b/%0b exp=1/0", DataMem_Read, M_Stall);
        end
        n_cmp++;
        if (DataMem_Address !== 30'h40) begin
            n_err++; $display("FAIL lw_addr got=%h exp=40", DataMem_Address);
        end
        pop_exp();
        n_cmp++;
        if (ReadData !== e) begin
            n_err++; $display("FAIL lw_rdata got=%h exp=%h", ReadData, e);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (DataMem_Read !== 1'b0) begin
            n_err++; $display("FAIL lw_one_cycle got=%0b exp=0", DataMem_Read);
        end
    endtask

    task automatic test_lb_wait();
        tick();
        Address = 32'h103; MemRead = 1; MemSignExtend = 1;
        DataMem_Ack = 0; DataMem_In = 32'h0;
        exp_q.push_back(32'hFFFFFFF0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (M_Stall !== 1'b1 || DataMem_Read !== 1'b1) begin
                n_err++;
                $display("FAIL lb_stall%0d got=%0b/%0b exp=1/1", i, M_Stall, DataMem_Read);
            end
            tick();
        end
        DataMem_Ack = 1; DataMem_In = 32'h000000F0;
        #1;
        pop_exp();
        n_cmp++;
        if (M_Stall !== 1'b0 || ReadData !== e) begin
            n_err++;
            $display("FAIL lb_ack got=%0b/%h exp=0/%h", M_Stall, ReadData, e);
        end
        tick();
        idle();
    endtask

    task automatic test_loads();
        logic [31:0] addr[5] = '{32'h102, 32'h100, 32'h100, 32'h101, 32'h102};
        logic        half[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        sx[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] din[5]  = '{32'h1234ABCD, 32'h8001FFFF, 32'h80112233,
                                 32'h00800000, 32'h0000C300};
        logic [31:0] res[5]  = '{32'h0000ABCD, 32'hFFFF8001, 32'h00000080,
                                 32'hFFFFFF80, 32'h000000C3};
        for (int i = 0; i < 5; i++) begin
            tick();
            Address = addr[i]; MemRead = 1; MemHalf = half[i];
            MemSignExtend = sx[i]; DataMem_In = din[i]; DataMem_Ack = 1;
            exp_q.push_back(res[i]);
            #1;
            pop_exp();
            n_cmp++;
            if (ReadData !== e) begin
                n_err++; $display("FAIL load%0d got=%h exp=%h", i, ReadData, e);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_stores();
        logic [31:0] addr[4] = '{32'h102, 32'h101, 32'h104, 32'h103};
        logic        word[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        half[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] din[4]  = '{32'h0000ABCD, 32'h0000005A, 32'hDEADBEEF, 32'h12345677};
        logic [3:0]  we[4]   = '{4'b0011, 4'b0100, 4'b1111, 4'b0001};
        logic [31:0] dout[4] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h77777777};
        for (int i = 0; i < 4; i++) begin
            tick();
            Address = addr[i]; MemWrite = 1; MemWord = word[i];
            MemHalf = half[i]; DataIn = din[i]; DataMem_Ack = 1;
            #1;
            n_cmp++;
            if (DataMem_Write !== we[i] || DataMem_Out !== dout[i]) begin
                n_err++;
                $display("FAIL store%0d got=%b/%h exp=%b/%h",
                         i, DataMem_Write, DataMem_Out, we[i], dout[i]);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_misaligned();
        tick();
        Address = 32'h101; MemRead = 1; MemWord = 1;
        #1;
        n_cmp++;
        if (EXC_AdEL !== 1'b1 || EXC_AdES !== 1'b0 ||
            DataMem_Read !== 1'b0 || M_Stall !== 1'b0) begin
            n_err++;
            $display("FAIL lw_misal got=%0b%0b%0b%0b exp=1000",
                     EXC_AdEL, EXC_AdES, DataMem_Read, M_Stall);
        end
        tick();
        idle();
        Address = 32'h103; MemRead = 1; MemHalf = 1;
        #1;
        n_cmp++;
        if (EXC_AdEL !== 1'b1 || DataMem_Read !== 1'b0) begin
            n_err++; $display("FAIL lh_misal got=%0b%0b exp=10", EXC_AdEL, DataMem_Read);
        end
        tick();
        idle();
        Address = 32'h102; MemWrite = 1; MemWord = 1;
        #1;
        n_cmp++;
        if (EXC_AdES !== 1'b1 || EXC_AdEL !== 1'b0 ||
            DataMem_Write !== 4'b0 || M_Stall !== 1'b0) begin
            n_err++;
            $display("FAIL sw_misal got=%0b%0b%b%0b exp=1000000",
                     EXC_AdES, EXC_AdEL, DataMem_Write, M_Stall);
        end
        tick();
        idle();
    endtask

    task automatic ll(input logic [31:0] a, input logic er);
        tick();
        idle();
        Address = a; MemRead = 1; MemWord = 1; LLSC = 1; Eret = er;
        DataMem_In = 32'hCAFEBABE; DataMem_Ack = 1;
        exp_q.push_back(32'hCAFEBABE);
        #1;
        pop_exp();
        n_cmp++;
        if (ReadData !== e) begin
            n_err++; $display("FAIL ll_rdata got=%h exp=%h", ReadData, e);
        end
    endtask

    task automatic sc(input logic [31:0] a, input logic ok, input string nm);
        tick();
        idle();
        Address = a; MemWrite = 1; MemWord = 1; LLSC = 1; DataIn = 32'h1;
        DataMem_Ack = ok;
        exp_q.push_back(ok ? 32'd1 : 32'd0);
        #1;
        pop_exp();
        n_cmp++;
        if (DataMem_Write !== (ok ? 4'b1111 : 4'b0000) ||
            ReadData !== e || M_Stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s got=%b/%h/%0b exp=%b/%h/0", nm, DataMem_Write,
                     ReadData, M_Stall, ok ? 4'b1111 : 4'b0000, e);
        end
    endtask

    task automatic test_llsc();
        ll(32'h200, 1'b0);
        sc(32'h200, 1'b1, "sc_ok");
        sc(32'h200, 1'b0, "sc_again");
        ll(32'h300, 1'b0);
        tick();
        idle();
        Address = 32'h300; MemWrite = 1; MemWord = 1; DataMem_Ack = 1;
        sc(32'h300, 1'b0, "sc_after_sw");
        ll(32'h400, 1'b1);
        sc(32'h400, 1'b0, "sc_eret_same");
        ll(32'h500, 1'b0);
        sc(32'h504, 1'b0, "sc_other_word");
        tick();
        idle();
        Eret = 1;
        sc(32'h500, 1'b0, "sc_after_eret");
        tick();
        idle();
    endtask

    task automatic test_if_stall();
        int strobes;
        strobes = 0;
        tick();
        Address = 32'h100; MemRead = 1; MemWord = 1; IF_Stall = 1;
        DataMem_In = 32'h55AA1234; DataMem_Ack = 1;
        exp_q.push_back(32'h55AA1234);
        #1;
        e = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            if (DataMem_Read === 1'b1) strobes++;
            n_cmp++;
            if (ReadData !== e || M_Stall !== 1'b0) begin
                n_err++;
                $display("FAIL hold%0d got=%h/%0b exp=%h/0", i, ReadData, M_Stall, e);
            end
            tick();
            DataMem_In = 32'hBAD0BAD0; DataMem_Ack = (i == 0);
            #1;
        end
        IF_Stall = 0;
        #1;
        if (DataMem_Read === 1'b1) strobes++;
        pop_exp();
        n_cmp++;
        if (ReadData !== e || strobes != 1) begin
            n_err++;
            $display("FAIL hold_release got=%h/%0d exp=%h/1", ReadData, strobes, e);
        end
        tick();
        DataMem_In = 32'h0BADF00D; DataMem_Ack = 1;
        #1;
        n_cmp++;
        if (DataMem_Read !== 1'b1 || ReadData !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL after_hold got=%0b/%h exp=1/0badf00d", DataMem_Read, ReadData);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_wait();
        ll(32'h600, 1'b0);
        tick();
        idle();
        Address = 32'h100; MemRead = 1; MemWord = 1;
        tick();
        #1;
        n_cmp++;
        if (M_Stall !== 1'b1) begin
            n_err++; $display("FAIL mid_wait_stall got=%0b exp=1", M_Stall);
        end
        reset = 1;
        tick();
        n_cmp++;
        if (DataMem_Read !== 1'b0 || M_Stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait got=%0b/%0b exp=0/0", DataMem_Read, M_Stall);
        end
        reset = 0;
        sc(32'h600, 1'b0, "sc_after_reset");
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_lw_zero_wait();
        test_lb_wait();
        test_loads();
        test_stores();
        test_misaligned();
        test_llsc();
        test_if_stall();
        test_reset_mid_wait();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
